add_seq: RTL and testbench
==========================

ADD_SEQ -- requirements
Module: add_seq

Interface
REQ-001 The block SHALL have one parameter: NBYTES, default 4, number of 8-bit bytes per operand (NBYTES >= 1); W = 8*NBYTES.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 in_a  input  W  first operand.
REQ-008 in_b  input  W  second operand.
REQ-009 in_sub  input  1  0 = a+b, 1 = a-b.
REQ-010 add_a  output  8  byte to the 8-bit adder's a.
REQ-011 add_b  output  8  byte to the 8-bit adder's b.
REQ-012 add_cin  output  1  carry to the 8-bit adder's cin.
REQ-013 add_sum  input  8  combinational sum from the 8-bit adder.
REQ-014 add_cout  input  1  combinational carry-out from the 8-bit adder.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_sum  output  W  result.
REQ-018 out_cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-019 out_ovf  output  1  signed two's-complement overflow.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-021 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-022 In IDLE, in_valid=1 at a clock edge SHALL latch a_reg=in_a, b_reg=(in_sub ? ~in_b : in_b), carry=in_sub, idx=0, clear the result, and go to RUN.
REQ-023 In RUN, add_a SHALL equal a_reg[8*idx+7:8*idx], add_b SHALL equal b_reg[8*idx+7:8*idx], and add_cin SHALL equal carry, all combinationally.
REQ-024 At each RUN edge the block SHALL store add_sum into result byte idx, set carry=add_cout, and increment idx.
REQ-025 At the RUN edge with idx=NBYTES-1, the block SHALL go to DONE, latch out_cout=add_cout, and latch out_ovf=(a_reg[W-1]==b_reg[W-1]) && (add_sum[7]!=a_reg[W-1]).
REQ-026 The block SHALL raise out_valid NBYTES edges after the accept edge; the minimum issue interval SHALL be NBYTES+2 cycles.
REQ-027 In IDLE and DONE, add_a, add_b and add_cin SHALL be driven to 0.
REQ-028 In DONE, out_sum, out_cout and out_ovf SHALL hold stable until out_ready=1; at that edge the block SHALL go to IDLE.
REQ-029 in_valid SHALL be ignored outside IDLE; no operand queuing.
REQ-030 All arithmetic SHALL be modulo 2^W; the carry out of byte NBYTES-1 SHALL appear only on out_cout.
REQ-031 With NBYTES=1, RUN SHALL last exactly one cycle.
REQ-032 out_sum, out_cout and out_ovf SHALL change only on the edge entering DONE, or on reset.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and clear idx, carry, a_reg, b_reg, out_sum, out_cout and out_ovf, independent of clk.
REQ-034 While rst=1, out_valid SHALL be 0, in_ready SHALL be 1, add_* SHALL be 0, and no operation SHALL be accepted.
REQ-035 Reset asserted in RUN or DONE SHALL abort the operation; no result SHALL be emitted for it.

Verification
REQ-036 Test: 0x000000FF + 0x00000001, sub=0 -> out_sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 edges after accept.
REQ-037 Test: 0xFFFFFFFF + 0x00000001 -> out_sum=0x00000000, cout=1, ovf=0.
REQ-038 Test: 0x7FFFFFFF + 0x00000001 -> out_sum=0x80000000, cout=0, ovf=1.
REQ-039 Test: 0x00000005 - 0x00000007 (sub=1) -> out_sum=0xFFFFFFFE, cout=0, ovf=0; byte 0 shows add_b=0xF8, add_cin=1.
REQ-040 Test: hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no new accept; on out_ready=1 -> IDLE, next op accepted.
REQ-041 Test: rst pulse during RUN byte 2 -> out_valid never rises, in_ready=1 after release; then 0x12345678 + 0x11111111 -> out_sum=0x23456789, cout=0.

Source files
------------

// File: rtl/add_seq.sv
// Sequential W-bit adder/subtractor built around an external 8-bit adder.
// One byte per cycle, least significant first; result is held until consumed.
module add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [IW+2:0]   w_sh;
  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [W-1:0]    w_acc_nxt;
  logic            w_last;
  logic            w_ovf;

  assign w_sh   = {r_idx, 3'b000};
  assign w_a_sh = r_a >> w_sh;
  assign w_b_sh = r_b >> w_sh;
  assign w_last = (r_idx == IW'(NBYTES - 1));
  assign w_ovf  = (r_a[W-1] == r_b[W-1]) &&
                  (add_sum[7] != r_a[W-1]);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (r_state == RUN) begin
      add_a   = w_a_sh[7:0];
      add_b   = w_b_sh[7:0];
      add_cin = r_carry;
    end
  end

  always_comb begin
    w_acc_nxt = r_acc;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == IW'(i))
        w_acc_nxt[8*i +: 8] = add_sum;
    end
  end

  // The working accumulator is separate from r_sum so the visible
  // result only moves on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub;
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_nxt;
          r_carry <= add_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_idx   <= '0;
            r_sum   <= w_acc_nxt;
            r_cout  <= add_cout;
            r_ovf   <= w_ovf;
          end
        end
        DONE: begin
          if (out_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// Directed and random checks of add_seq against an arithmetic model.
// The 8-bit adder is modelled combinationally inside the bench.
module tb_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} =
    {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  add_seq #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input  logic [W-1:0] a,
                                input  logic [W-1:0] b,
                                input  logic         sub,
                                output logic [W-1:0] s,
                                output logic         c,
                                output logic         v);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    if (sub) begin
      s = W'(ua - ub);
      c = (ua >= ub);
      r = sa - sb;
    end else begin
      s = W'(ua + ub);
      c = ((ua + ub) >> W) != 0;
      r = sa + sb;
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic op(input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic         sub,
                    input bit           hold,
                    input string        tag);
    logic [W-1:0] es;
    logic         ec;
    logic         ev;
    int           n;
    model(a, b, sub, es, ec, ev);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    chk({tag, ".busy"}, 64'(in_ready), 64'd0);
    chk({tag, ".b0"},
        {47'd0, add_a, add_b, add_cin},
        {47'd0, a[7:0], (sub ? ~b[7:0] : b[7:0]), sub});
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'(NB));
    chk({tag, ".sum"}, 64'(out_sum), 64'(es));
    chk({tag, ".cv"}, {62'd0, out_cout, out_ovf}, {62'd0, ec, ev});
    chk({tag, ".addz"}, {47'd0, add_a, add_b, add_cin}, 64'd0);
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_a = $urandom;
        in_b = $urandom;
        @(posedge clk);
        #1;
        chk({tag, ".hold"},
            {29'd0, out_valid, in_ready, out_cout, out_sum},
            {29'd0, 1'b1, 1'b0, ec, es});
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           seen;
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 32'h1;
    in_b = 32'h1;
    in_sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ctl", {62'd0, in_ready, out_valid}, 64'd2);
    chk("rst.out", {31'd0, out_cout, out_ovf, out_sum}, 64'd0);
    chk("rst.add", {47'd0, add_a, add_b, add_cin}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, "carry8");
    chk("carry8.lit", 64'(out_sum), 64'h100);
    op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "wrap");
    op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "ovf");
    op(32'h00000005, 32'h00000007, 1'b1, 1'b0, "sub");
    chk("sub.lit", {31'd0, out_cout, out_ovf, out_sum},
        {31'd0, 1'b0, 1'b0, 32'hFFFFFFFE});
    op(32'h80000000, 32'h00000001, 1'b1, 1'b0, "subovf");
    op(32'h0000ABCD, 32'h0000ABCD, 1'b1, 1'b1, "holdop");
    op(32'h00000010, 32'h00000020, 1'b0, 1'b0, "after");

    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'hA1B2C3D4;
    in_b = 32'h01020304;
    in_sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("abort.b2", 64'(add_a), 64'hB2);
    rst = 1'b1;
    #1;
    chk("abort.ctl", {62'd0, in_ready, out_valid}, 64'd2);
    chk("abort.add", {47'd0, add_a, add_b, add_cin}, 64'd0);
    chk("abort.out", {31'd0, out_cout, out_ovf, out_sum}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort.nov", 64'(seen), 64'd0);
    chk("abort.rdy", 64'(in_ready), 64'd1);
    op(32'h12345678, 32'h11111111, 1'b0, 1'b0, "post");
    chk("post.lit", {31'd0, out_cout, out_sum}, {31'd0, 1'b0, 32'h23456789});

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 1) rb = ra;
      if (i % 8 == 2) ra = 32'h7FFFFFFF;
      if (i % 8 == 3) rb = 32'h80000000;
      op(ra, rb, 1'($urandom_range(0, 1)),
         (i % 10 == 5), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
